// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, stop hold and flush.
// Optional macro PIPE_SKID_EN adds a second skid entry so that in_ready is driven from a flop.
module pipe_stage_reg #(
    parameter int unsigned     WIDTH    = 96,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stop,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [1:0]       occ_q,        occ_d;
    logic             accept;
    logic             drain;

    assign drain  = main_valid_q & out_ready & ~stop;
    assign accept = in_valid & in_ready;

`ifdef PIPE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    // Ready depends only on registered skid state, never on downstream signals.
    assign in_ready = ~skid_valid_q & ~rst & ~flush;

    // Next-state: main entry always holds the oldest payload, skid the younger one.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_DATA;
            skid_valid_d = 1'b0;
            skid_data_d  = RST_DATA;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
        occ_d = 2'(main_valid_d) + 2'(skid_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RST_DATA;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Single entry: a slot frees up in the same cycle the held payload drains.
    assign in_ready = ~flush & ~rst & (~main_valid_q | (out_ready & ~stop));

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_DATA;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
        occ_d = 2'(main_valid_d);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RST_DATA;
            occ_q        <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            occ_q        <= occ_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed literal checks.
// Exercises the skid variant when PIPE_SKID_EN is defined.
module tb_pipe_stage_reg;

    localparam int unsigned W = 96;
    localparam logic [W-1:0] RST = 96'h0000_0000_0000_0000_0BAD_F00D;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, stop, flush;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] last_data;
    bit           model_ok = 1'b0;

    pipe_stage_reg #(.WIDTH(W), .RST_DATA(RST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stop(stop), .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready as the rules state it: free slot (or draining slot in single-entry mode), no rst/flush.
    function automatic bit exp_rdy();
        if (rst || flush) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || (out_ready && !stop);
    endfunction

    // Reference model: FIFO of held payloads, front is what out_data shows.
    always @(posedge clk) begin
        bit acc, drn;
        acc = in_valid && exp_rdy();
        drn = (q.size() != 0) && out_ready && !stop;
        if (rst) begin
            q.delete();
            last_data = RST;
            model_ok  = 1'b1;
        end else if (flush) begin
            q.delete();
            last_data = RST;
        end else begin
            if (drn) last_data = q.pop_front();
            if (acc) q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready",  W'(in_ready),  W'(exp_rdy()));
            chk("out_valid", W'(out_valid), W'(q.size() != 0));
            chk("occupancy", W'(occupancy), W'(q.size()));
            chk("out_data",  out_data, (q.size() != 0) ? q[0] : last_data);
        end
    end

    task automatic step(input logic r, input logic f, input logic v, input logic [W-1:0] d,
                        input logic o, input logic s);
        @(posedge clk);
        #1;
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = o; stop = s;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'(32'hA5);
        out_ready = 1'b1; stop = 1'b0;

        // Reset with a payload presented
        step(1, 0, 1, W'(32'hA5), 1, 0);
        step(1, 0, 1, W'(32'hA5), 1, 0);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data",  out_data, RST);
        chk("rst_occ",       W'(occupancy), W'(0));
        chk("rst_in_ready",  W'(in_ready), W'(0));
        step(0, 0, 0, '0, 1, 0);
        chk("post_rst_in_ready", W'(in_ready), W'(1));

        // Back-to-back streaming of 1..8
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, i <= 8, W'(i), 1, 0);
            if (i >= 2) begin
                chk("stream_data",  out_data, W'(i - 1));
                chk("stream_valid", W'(out_valid), W'(1));
            end
        end

        // Stop hold
        step(0, 0, 1, W'(32'h55), 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, 1, 1);
            chk("stop_data",  out_data, W'(32'h55));
            chk("stop_valid", W'(out_valid), W'(1));
            if (CAP == 1) chk("stop_in_ready", W'(in_ready), W'(0));
        end
        step(0, 0, 0, '0, 1, 0);
        chk("stop_release_data", out_data, W'(32'h55));
        step(0, 0, 0, '0, 1, 0);
        chk("stop_drained", W'(out_valid), W'(0));

        // Flush with a concurrent input
        step(0, 0, 1, W'(32'h77), 0, 0);
        step(0, 1, 1, W'(32'h99), 0, 0);
        chk("flush_pre_data", out_data, W'(32'h77));
        chk("flush_pre_occ",  W'(occupancy), W'(1));
        chk("flush_in_ready", W'(in_ready), W'(0));
        step(0, 0, 0, '0, 1, 0);
        chk("flush_valid", W'(out_valid), W'(0));
        chk("flush_data",  out_data, RST);
        chk("flush_occ",   W'(occupancy), W'(0));
        step(0, 0, 0, '0, 1, 0);
        chk("flush_no_99", out_data, RST);

`ifdef PIPE_SKID_EN
        // Skid fill and ordered drain
        step(0, 0, 1, W'(32'h10), 0, 0);
        step(0, 0, 1, W'(32'h20), 0, 0);
        chk("skid_occ1", W'(occupancy), W'(1));
        chk("skid_rdy1", W'(in_ready), W'(1));
        step(0, 0, 0, '0, 0, 0);
        chk("skid_occ2", W'(occupancy), W'(2));
        chk("skid_rdy0", W'(in_ready), W'(0));
        chk("skid_main", out_data, W'(32'h10));
        step(0, 0, 0, '0, 1, 0);
        chk("skid_out10", out_data, W'(32'h10));
        step(0, 0, 0, '0, 1, 0);
        chk("skid_out20", out_data, W'(32'h20));
        chk("skid_occ_back1", W'(occupancy), W'(1));
        chk("skid_rdy_back", W'(in_ready), W'(1));
        step(0, 0, 0, '0, 1, 0);
        chk("skid_empty", W'(out_valid), W'(0));

        // Skid flush while full
        step(0, 0, 1, W'(32'h31), 0, 0);
        step(0, 0, 1, W'(32'h32), 0, 0);
        step(0, 1, 0, '0, 1, 0);
        chk("skidf_occ2", W'(occupancy), W'(2));
        step(0, 0, 0, '0, 1, 0);
        chk("skidf_occ0",  W'(occupancy), W'(0));
        chk("skidf_valid", W'(out_valid), W'(0));
        chk("skidf_data",  out_data, RST);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(9) < 7,
                 {$urandom, $urandom, $urandom}, $urandom_range(9) < 6, $urandom_range(4) == 0);
        end
        step(0, 0, 0, '0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
